// File: rtl/arm_pkg.sv
// arm_pkg: shared ALU command codes and NZCV flag bit positions.
package arm_pkg;
    typedef enum logic [3:0] {
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/flag_calc.sv
// flag_calc: combinational next-NZCV from the EXE-stage ALU result.
module flag_calc
    import arm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        exe_cmd,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_cout,
    input  logic              c_in,
    input  logic              v_in,
    output logic [3:0]        flags
);
    logic is_add, is_sub, a_s, b_s, r_s, unused_bits;
    assign unused_bits = ^{alu_a[DATA_W-2:0], alu_b[DATA_W-2:0]};
    always_comb begin
        is_add = (exe_cmd == EXE_ADD) || (exe_cmd == EXE_ADC);
        is_sub = (exe_cmd == EXE_SUB) || (exe_cmd == EXE_SBC);
        a_s    = alu_a[DATA_W-1];
        b_s    = alu_b[DATA_W-1];
        r_s    = alu_res[DATA_W-1];
        flags[FLAG_N] = r_s;
        flags[FLAG_Z] = (alu_res == '0);
        flags[FLAG_C] = (is_add || is_sub) ? alu_cout : c_in;
        flags[FLAG_V] = is_add ? ((a_s == b_s) && (r_s != a_s)) :
                        is_sub ? ((a_s != b_s) && (r_s != a_s)) : v_in;
    end
endmodule

// File: rtl/status_flag_unit.sv
// status_flag_unit: NZCV status register with shadow, sticky V and optional SR_FWD_EN bypass.
module status_flag_unit
    import arm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        exe_cmd,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_cout,
    input  logic              valid,
    input  logic              s_bit,
    input  logic              cond_pass,
    input  logic              freeze,
    input  logic              flush,
    input  logic              save,
    input  logic              restore,
    input  logic              clr_sticky,
    output logic [3:0]        sr,
    output logic [3:0]        sr_shadow,
    output logic              sticky_v
);
    logic [3:0] sr_q, sr_d, shadow_q, shadow_d, nzcv;
    logic       sticky_q, sticky_d, commit;
    flag_calc #(.DATA_W(DATA_W)) u_calc (
        .exe_cmd (exe_cmd),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_res (alu_res),
        .alu_cout(alu_cout),
        .c_in    (sr_q[FLAG_C]),
        .v_in    (sr_q[FLAG_V]),
        .flags   (nzcv)
    );
    always_comb begin
        commit   = valid & s_bit & cond_pass & ~freeze & ~flush;
        sr_d     = (restore & ~freeze) ? shadow_q : commit ? nzcv : sr_q;
        shadow_d = (save & ~freeze) ? sr_q : shadow_q;
        sticky_d = (commit & nzcv[FLAG_V]) | (sticky_q & ~(clr_sticky & ~freeze));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= '0;
            shadow_q <= '0;
            sticky_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            shadow_q <= shadow_d;
            sticky_q <= sticky_d;
        end
    end
`ifdef SR_FWD_EN
    assign sr = (commit & ~restore) ? nzcv : sr_q;
`else
    assign sr = sr_q;
`endif
    assign sr_shadow = shadow_q;
    assign sticky_v  = sticky_q;
endmodule

// File: tb/tb_status_flag_unit.sv
// tb_status_flag_unit: directed scoreboard bench for status_flag_unit.
module tb_status_flag_unit;
    logic        clk = 1'b0;
    logic        rst, alu_cout, valid, s_bit, cond_pass, freeze, flush, save, restore, clr_sticky;
    logic [3:0]  exe_cmd, sr, sr_shadow;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        sticky_v;
    int          errors = 0;
    int          checks = 0;
    typedef struct packed {
        logic [3:0] sr;
        logic [3:0] sh;
        logic       st;
    } exp_t;
    exp_t sb[$];
    always #5 clk = ~clk;
    status_flag_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .exe_cmd(exe_cmd), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_cout(alu_cout), .valid(valid), .s_bit(s_bit),
        .cond_pass(cond_pass), .freeze(freeze), .flush(flush), .save(save),
        .restore(restore), .clr_sticky(clr_sticky), .sr(sr), .sr_shadow(sr_shadow),
        .sticky_v(sticky_v)
    );
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic tick(input string tag, input logic [3:0] e_sr, input logic [3:0] e_sh, input logic e_st);
        exp_t e;
        sb.push_back('{e_sr, e_sh, e_st});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".sr"}, sr, e.sr);
        chk({tag, ".shadow"}, sr_shadow, e.sh);
        chk({tag, ".sticky"}, {3'b0, sticky_v}, {3'b0, e.st});
    endtask
    task automatic idle();
        rst = 0; valid = 0; s_bit = 0; cond_pass = 0; freeze = 0; flush = 0;
        save = 0; restore = 0; clr_sticky = 0;
    endtask
    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic co);
        exe_cmd = c; alu_a = a; alu_b = b; alu_res = r; alu_cout = co;
        valid = 1; s_bit = 1; cond_pass = 1;
    endtask
    initial begin
        idle();
        op(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        rst = 1; save = 1;
        tick("reset", 4'b0000, 4'b0000, 1'b0);
        idle();
        op(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        tick("add_ovf", 4'b1001, 4'b0000, 1'b1);
        op(4'b0100, 32'h5, 32'h5, 32'h0, 1'b1);
        tick("sub_zero", 4'b0110, 4'b0000, 1'b1);
        op(4'b0100, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1);
        tick("sub_ovf", 4'b0011, 4'b0000, 1'b1);
        op(4'b0110, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0);
        tick("and_keep_cv", 4'b1011, 4'b0000, 1'b1);
        idle(); clr_sticky = 1;
        tick("clr_sticky", 4'b1011, 4'b0000, 1'b0);
        idle();
        op(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0); s_bit = 0;
        tick("no_sbit", 4'b1011, 4'b0000, 1'b0);
        s_bit = 1; cond_pass = 0;
        tick("no_cond", 4'b1011, 4'b0000, 1'b0);
        cond_pass = 1; flush = 1;
        tick("flush", 4'b1011, 4'b0000, 1'b0);
        flush = 0; freeze = 1; save = 1; restore = 1;
        tick("freeze_all", 4'b1011, 4'b0000, 1'b0);
        idle();
        op(4'b0100, 32'h5, 32'h5, 32'h0, 1'b1);
        tick("sub_zero2", 4'b0110, 4'b0000, 1'b0);
        idle(); save = 1;
        tick("save", 4'b0110, 4'b0110, 1'b0);
        idle();
        op(4'b0010, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0);
        #1;
`ifdef SR_FWD_EN
        chk("fwd_commit", sr, 4'b1000);
`else
        chk("reg_commit", sr, 4'b0110);
`endif
        tick("commit_1000", 4'b1000, 4'b0110, 1'b0);
        restore = 1;
        #1;
        chk("restore_cycle_sr", sr, 4'b1000);
        tick("restore", 4'b0110, 4'b0110, 1'b0);
        idle();
        op(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        tick("add_ovf2", 4'b1001, 4'b0110, 1'b1);
        idle(); save = 1; restore = 1;
        tick("swap", 4'b0110, 4'b1001, 1'b1);
        idle(); freeze = 1; clr_sticky = 1; save = 1; restore = 1;
        tick("freeze_clr", 4'b0110, 4'b1001, 1'b1);
        idle();
        op(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0); flush = 1; save = 1;
        tick("flush_save", 4'b0110, 4'b0110, 1'b1);
        idle();
        op(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0); clr_sticky = 1;
        tick("set_beats_clr", 4'b1001, 4'b0110, 1'b1);
        idle(); rst = 1;
        tick("reset2", 4'b0000, 4'b0000, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
